// File: rtl/jtcps1_sdram_pkg.sv
// Shared SDRAM definitions for the CPS1 ROM-download programming port:
// command encodings {cs_n,ras_n,cas_n,we_n}, controller states and address helpers.
package jtcps1_sdram_pkg;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    // Address bit that selects auto-precharge on WRITE / all-banks on PRECHARGE
    localparam int AUTOPRE = 10;

    localparam logic [12:0] A_PREALL = 13'd1 << AUTOPRE;

    typedef enum logic [3:0] {
        ST_INIT_WAIT = 4'd0,
        ST_INIT_PRE  = 4'd1,
        ST_INIT_REF  = 4'd2,
        ST_INIT_MODE = 4'd3,
        ST_IDLE      = 4'd4,
        ST_ACT       = 4'd5,
        ST_WRITE     = 4'd6,
        ST_WAIT_WR   = 4'd7,
        ST_REFRESH   = 4'd8
    } state_t;

    // Column address with the auto-precharge bit set
    function automatic logic [12:0] col_addr(input logic [8:0] col);
        return {4'b0000, col} | A_PREALL;
    endfunction

endpackage

// File: rtl/jtcps1_sdram_init.sv
// SDRAM power-up sequencer: wait, PRECHARGE ALL, two REFRESH, LOAD MODE.
// Its command/address outputs are only used until init_done rises.
module jtcps1_sdram_init
    import jtcps1_sdram_pkg::*;
#(
    parameter int          INIT_CYCLES = 4800,
    parameter int          TRFC        = 7,
    parameter logic [12:0] MODE        = 13'h020
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  cmd,
    output logic [12:0] a,
    output logic        init_done
);

    state_t      state_r;
    logic [15:0] cnt_r;
    logic        ref_two_r;

    // Init sequencer: one command per step, fixed recovery gaps between steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_INIT_WAIT;
            cnt_r     <= 16'd0;
            ref_two_r <= 1'b0;
            cmd       <= CMD_NOP;
            a         <= 13'd0;
            init_done <= 1'b0;
        end else begin
            cmd <= CMD_NOP;
            case (state_r)
                ST_INIT_WAIT: begin
                    if (cnt_r == 16'(INIT_CYCLES - 1)) begin
                        cnt_r   <= 16'd0;
                        cmd     <= CMD_PRE;
                        a       <= A_PREALL;
                        state_r <= ST_INIT_PRE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_INIT_PRE: begin
                    if (cnt_r == 16'(TRFC - 1)) begin
                        cnt_r     <= 16'd0;
                        cmd       <= CMD_REF;
                        ref_two_r <= 1'b0;
                        state_r   <= ST_INIT_REF;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_INIT_REF: begin
                    if (cnt_r == 16'(TRFC - 1)) begin
                        cnt_r <= 16'd0;
                        if (ref_two_r) begin
                            cmd     <= CMD_MRS;
                            a       <= MODE;
                            state_r <= ST_INIT_MODE;
                        end else begin
                            cmd       <= CMD_REF;
                            ref_two_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_INIT_MODE: begin
                    if (cnt_r == 16'd1) begin
                        cnt_r     <= 16'd0;
                        a         <= 13'd0;
                        init_done <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_IDLE: begin
                    cnt_r <= 16'd0;
                end
                default: begin
                    cnt_r   <= 16'd0;
                    state_r <= ST_INIT_WAIT;
                end
            endcase
        end
    end

endmodule

// File: rtl/jtcps1_prog_sdram.sv
// ROM-download SDRAM writer: init, single-word writes with auto-precharge,
// periodic refresh and a one-cycle ack per completed write.
// Optional: define JTCPS1_PROG_CHECKSUM_EN to add the prog_sum byte checksum output.
module jtcps1_prog_sdram
    import jtcps1_sdram_pkg::*;
#(
    parameter int          INIT_CYCLES = 4800,
    parameter int          REF_CYCLES  = 374,
    parameter int          TRCD        = 2,
    parameter int          TWRP        = 4,
    parameter int          TRFC        = 7,
    parameter logic [12:0] MODE        = 13'h020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    input  logic [1:0]  prog_bank,
    input  logic        prog_we,
    output logic        sdram_ack,
    output logic        init_done,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_a,
    output logic [15:0] sdram_dq,
    output logic        sdram_dq_oe,
    output logic [1:0]  sdram_dqm
`ifdef JTCPS1_PROG_CHECKSUM_EN
   ,output logic [15:0] prog_sum
`endif
);

    logic [3:0]  init_cmd_s;
    logic [12:0] init_a_s;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [3:0]  cmd_r;
    logic [12:0] a_r;
    logic [8:0]  col_r;
    logic [7:0]  data_r;
    logic [1:0]  mask_r;
    logic [15:0] ref_cnt_r;
    logic        ref_due_r;
    logic        blank_r;

    logic        req_s;
    logic        ref_issue_s;
    logic        ack_set_s;

    jtcps1_sdram_init #(
        .INIT_CYCLES (INIT_CYCLES),
        .TRFC        (TRFC),
        .MODE        (MODE)
    ) u_init (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (init_cmd_s),
        .a         (init_a_s),
        .init_done (init_done)
    );

    // The sequencer owns cmd/a until init completes; both sources are registers
    assign sdram_cmd = init_done ? cmd_r : init_cmd_s;
    assign sdram_a   = init_done ? a_r   : init_a_s;

    // blank covers the ack cycle and the one after, hiding a stale prog_we
    assign req_s       = prog_we && downloading && !sdram_ack && !blank_r;
    assign ref_issue_s = (state_r == ST_IDLE) && ref_due_r;
    assign ack_set_s   = (state_r == ST_WAIT_WR) && (cnt_r == 4'(TWRP));

    // Refresh interval counter; runs free once init is done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_cnt_r <= 16'd0;
            ref_due_r <= 1'b0;
        end else if (!init_done) begin
            ref_cnt_r <= 16'd0;
            ref_due_r <= 1'b0;
        end else if (ref_cnt_r == 16'(REF_CYCLES - 1)) begin
            ref_cnt_r <= 16'd0;
            ref_due_r <= 1'b1;
        end else begin
            ref_cnt_r <= ref_cnt_r + 16'd1;
            if (ref_issue_s) begin
                ref_due_r <= 1'b0;
            end else begin
                ref_due_r <= ref_due_r;
            end
        end
    end

    // Delayed ack, second half of the blank window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_r <= 1'b0;
        end else begin
            blank_r <= sdram_ack;
        end
    end

    // Main controller: refresh has priority over a pending write request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT_WAIT;
            cnt_r       <= 4'd0;
            cmd_r       <= CMD_NOP;
            a_r         <= 13'd0;
            sdram_ba    <= 2'd0;
            sdram_dq    <= 16'd0;
            sdram_dq_oe <= 1'b0;
            sdram_dqm   <= 2'b11;
            sdram_ack   <= 1'b0;
            col_r       <= 9'd0;
            data_r      <= 8'd0;
            mask_r      <= 2'b11;
        end else begin
            cmd_r       <= CMD_NOP;
            sdram_ack   <= 1'b0;
            sdram_dq_oe <= 1'b0;
            sdram_dqm   <= 2'b11;
            case (state_r)
                ST_INIT_WAIT: begin
                    if (init_done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_INIT_WAIT;
                    end
                end
                ST_IDLE: begin
                    cnt_r <= 4'd0;
                    if (ref_due_r) begin
                        cmd_r   <= CMD_REF;
                        state_r <= ST_REFRESH;
                    end else if (req_s) begin
                        col_r    <= prog_addr[8:0];
                        data_r   <= prog_data;
                        mask_r   <= prog_mask;
                        cmd_r    <= CMD_ACT;
                        sdram_ba <= prog_bank;
                        a_r      <= prog_addr[21:9];
                        state_r  <= ST_ACT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACT: begin
                    if (cnt_r == 4'(TRCD - 1)) begin
                        cnt_r       <= 4'd0;
                        cmd_r       <= CMD_WR;
                        a_r         <= col_addr(col_r);
                        sdram_dq    <= {data_r, data_r};
                        sdram_dqm   <= mask_r;
                        sdram_dq_oe <= 1'b1;
                        state_r     <= ST_WRITE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_WRITE: begin
                    cnt_r   <= 4'd0;
                    state_r <= ST_WAIT_WR;
                end
                ST_WAIT_WR: begin
                    if (ack_set_s) begin
                        cnt_r     <= 4'd0;
                        sdram_ack <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_REFRESH: begin
                    if (cnt_r == 4'(TRFC - 1)) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    cnt_r   <= 4'd0;
                    state_r <= ST_INIT_WAIT;
                end
            endcase
        end
    end

`ifdef JTCPS1_PROG_CHECKSUM_EN
    logic dl_r;

    // Running byte sum of written data, restarted at each download start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_r     <= 1'b0;
            prog_sum <= 16'd0;
        end else begin
            dl_r <= downloading;
            if (downloading && !dl_r) begin
                prog_sum <= 16'd0;
            end else if (ack_set_s) begin
                prog_sum <= prog_sum + {8'd0, data_r};
            end else begin
                prog_sum <= prog_sum;
            end
        end
    end
`endif

endmodule
